// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads WORD_COUNT words from BASE_ADDR and streams them out as big-endian bytes.
// Define DUMP_CHECKSUM_EN to append a two's-complement checksum byte after the data.
module mem_dump_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          WORD_COUNT = 300,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] mem_address_o,
    output logic        mem_read_enabled_o,
    input  logic [31:0] mem_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, CKSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, DONE} state_t;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_COUNT);
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [31:0]          word_q, addr_q;
    logic [7:0]           tx_data_q;
    logic                 busy_q, done_q, re_q, tx_valid_q, accept;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]           sum_q, sum_d;
    assign sum_d = sum_q + tx_data_q;
`endif
    assign cnt_d  = cnt_q + CNT_WIDTH'(1);
    assign idx_d  = idx_q - 2'd1;
    assign accept = tx_valid_q & tx_ready_i;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            word_q     <= '0;
            addr_q     <= BASE_ADDR;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            re_q       <= 1'b0;
            tx_valid_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
                    sum_q  <= '0;
`endif
                    if (WORD_COUNT == 0) begin
`ifdef DUMP_CHECKSUM_EN
                        state_q    <= CKSUM;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b1;
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= REQ;
                        addr_q  <= BASE_ADDR;
                        re_q    <= 1'b1;
                    end
                end
                REQ: begin
                    state_q <= LATCH;
                    re_q    <= 1'b0;
                end
                LATCH: begin
                    state_q    <= SEND;
                    word_q     <= mem_data_i;
                    idx_q      <= 2'd3;
                    tx_data_q  <= mem_data_i[31:24];
                    tx_valid_q <= 1'b1;
                end
                SEND: if (accept) begin
`ifdef DUMP_CHECKSUM_EN
                    sum_q <= sum_d;
`endif
                    if (idx_q != 2'd0) begin
                        idx_q     <= idx_d;
                        tx_data_q <= 8'(word_q >> {idx_d, 3'b000});
                    end else begin
                        cnt_q      <= cnt_d;
                        tx_valid_q <= 1'b0;
                        if (cnt_d != LAST) begin
                            state_q <= REQ;
                            addr_q  <= BASE_ADDR + 32'(cnt_d);
                            re_q    <= 1'b1;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            state_q    <= CKSUM;
                            tx_data_q  <= -sum_d;
                            tx_valid_q <= 1'b1;
`else
                            state_q <= DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CKSUM: if (accept) begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    tx_valid_q <= 1'b0;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign mem_address_o      = addr_q;
    assign mem_read_enabled_o = re_q;
    assign tx_data_o          = tx_data_q;
    assign tx_valid_o         = tx_valid_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed checks of mem_dump_reader with a 2-word and a 0-word instance.
module tb_mem_dump_reader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_z = 1'b0, ready = 1'b1;
    logic        busy, done, re, valid, busy_z, done_z, re_z, valid_z;
    logic [31:0] addr, addr_z, mdata;
    logic [7:0]  data, data_z;
    logic        re_z_seen = 1'b0;
    int          checks = 0, errors = 0;
    logic [7:0]  bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  cks;

    always #5 clk = ~clk;

    mem_dump_reader #(.BASE_ADDR(32'd0), .WORD_COUNT(2), .CNT_WIDTH(16)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .mem_address_o(addr), .mem_read_enabled_o(re), .mem_data_i(mdata),
        .tx_data_o(data), .tx_valid_o(valid), .tx_ready_i(ready));

    mem_dump_reader #(.BASE_ADDR(32'd0), .WORD_COUNT(0), .CNT_WIDTH(16)) dz (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start_z), .busy_o(busy_z), .done_o(done_z),
        .mem_address_o(addr_z), .mem_read_enabled_o(re_z), .mem_data_i(32'h0),
        .tx_data_o(data_z), .tx_valid_o(valid_z), .tx_ready_i(ready));

    // Registered-read memory; outside a read the port shows junk so late captures get caught.
    always @(posedge clk)
        mdata <= re ? (addr == 32'd0 ? 32'h12345678 : addr == 32'd1 ? 32'hDEADBEEF : 32'h0)
                    : 32'hA5A5A5A5;
    always @(posedge clk) if (re_z) re_z_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_basic(input string tag);
        start = 1'b1; tick(); start = 1'b0;
        check({tag, "_req_busy"}, busy, 1);
        check({tag, "_req_re"}, re, 1);
        check({tag, "_req_addr0"}, addr, 0);
        check({tag, "_req_valid"}, valid, 0);
        tick();
        check({tag, "_latch_re"}, re, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_w0_valid"}, valid, 1);
            check({tag, "_w0_byte"}, data, bytes[i]);
        end
        tick();
        check({tag, "_req1_re"}, re, 1);
        check({tag, "_req1_addr1"}, addr, 1);
        check({tag, "_req1_valid"}, valid, 0);
        tick();
        for (int i = 4; i < 8; i++) begin
            tick();
            check({tag, "_w1_valid"}, valid, 1);
            check({tag, "_w1_byte"}, data, bytes[i]);
        end
        tick();
`ifdef DUMP_CHECKSUM_EN
        check({tag, "_cks_valid"}, valid, 1);
        check({tag, "_cks_byte"}, data, cks);
        check({tag, "_cks_nodone"}, done, 0);
        tick();
`endif
        check({tag, "_done"}, done, 1);
        check({tag, "_done_busy"}, busy, 1);
        check({tag, "_done_addr_hold"}, addr, 1);
        check({tag, "_done_valid"}, valid, 0);
        tick();
        check({tag, "_after_done"}, done, 0);
        check({tag, "_after_busy"}, busy, 0);
    endtask

    initial begin
        cks = 8'h00;
        for (int i = 0; i < 8; i++) cks = cks - bytes[i];
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        check("rst_re", re, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        rst_n = 1'b1;
        tick();

        run_basic("basic");

        // Zero-length dump on the second instance.
        start_z = 1'b1; tick(); start_z = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        check("zero_cks_valid", valid_z, 1);
        check("zero_cks_byte", data_z, 0);
        tick();
`endif
        check("zero_done", done_z, 1);
        check("zero_busy", busy_z, 1);
        check("zero_re", re_z, 0);
        tick();
        check("zero_done_clr", done_z, 0);
        check("zero_busy_clr", busy_z, 0);
        check("zero_valid_never", valid_z, 0);
        check("zero_no_reads", re_z_seen, 0);

        // Backpressure: 5 stall cycles on 0x56, then ready alternates.
        begin
            int n = 0, stall = 0, ndone = 0;
`ifdef DUMP_CHECKSUM_EN
            int nb = 9;
`else
            int nb = 8;
`endif
            start = 1'b1; tick(); start = 1'b0;
            for (int cyc = 0; cyc < 100 && ndone == 0; cyc++) begin
                if (n == 2 && valid && stall < 5) begin
                    ready = 1'b0;
                    stall++;
                end else ready = (n > 2) ? cyc[0] : 1'b1;
                if (valid && ready) begin
                    check("bp_byte", data, n < 8 ? bytes[n] : cks);
                    n++;
                end else if (valid && n == 2)
                    check("bp_stall_hold", data, 8'h56);
                tick();
                if (done) ndone++;
            end
            ready = 1'b1;
            check("bp_count", n, nb);
            check("bp_stalls", stall, 5);
            check("bp_done_seen", ndone, 1);
            tick();
            check("bp_busy_clr", busy, 0);
        end

        // Start while busy is ignored, then asynchronous reset mid-dump.
        start = 1'b1; tick(); start = 1'b0;
        repeat (8) tick();
        check("mid_byte_de", data, 8'hDE);
        start = 1'b1; tick(); start = 1'b0;
        check("ignore_start_byte", data, 8'hAD);
        check("ignore_start_busy", busy, 1);
        tick();
        check("pre_rst_byte", data, 8'hBE);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", valid, 0);
        check("async_data", data, 0);
        check("async_addr", addr, 0);
        check("async_re", re, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);
        run_basic("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
